// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential reads and buffers {instr, pc} in a FIFO.
// Optional build macro PREFETCH_STATS_EN adds discard_count_o (instructions thrown away by flushes).
module instr_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          halt_i,
  input  logic          flush_i,
  input  logic [AW-1:0] flush_pc_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_q_i,
  output logic          instr_valid_o,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
`ifdef PREFETCH_STATS_EN
  output logic [15:0]   discard_count_o,
`endif
  input  logic          instr_take_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [DW-1:0] instr_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q    [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue;
  logic          wr_en;
  logic          pop;

  // Credit counts the in-flight read so a returning response always has a free slot.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  // Gating with reset keeps mem_req low during the reset cycle itself.
  assign issue     = !reset_i && !halt_i && !flush_i && (occupancy < (CW+1)'(DEPTH));
  assign wr_en     = inflight_q && !flush_i;
  assign pop       = instr_take_i && (count_q != '0) && !flush_i;

  assign mem_req_o     = issue;
  assign mem_addr_o    = fetch_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q]    : '0;

  // NOTE: every always_comb target gets a default first so no latch can be inferred.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        tag_d      = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + AW'(1);
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fetch_pc_q <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; count gates the outputs, so stale slots are never visible.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      instr_mem_q[wr_ptr_q] <= mem_q_i;
      pc_mem_q[wr_ptr_q]    <= tag_q;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] discard_count_q;
  logic [16:0] discard_sum;

  assign discard_sum     = {1'b0, discard_count_q} + 17'(occupancy);
  assign discard_count_o = discard_count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      discard_count_q <= '0;
    end else if (flush_i) begin
      discard_count_q <= discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
    end
  end
`endif

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the multicycle datapath's IR register.
- Owns the fetch PC and issues sequential reads on the instruction port of the dual-port memory.
- Buffers the returned instruction bytes, each tagged with its PC, in a small FIFO.
- Presents the oldest entry to the control/IR load logic through a valid/take handshake; redirects on branch via flush.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- AW, 8, address/PC width in bits.
- DW, 8, instruction width in bits.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  when 1, no new memory requests are issued; in-flight response is still accepted.
- flush  in  1  redirect: discard all queued and in-flight instructions.
- flush_pc  in  AW  new fetch PC, sampled when flush=1.
- mem_req  out  1  a read of mem_addr is issued this cycle.
- mem_addr  out  AW  instruction read address, equal to the current fetch PC.
- mem_q  in  DW  read data; valid exactly one cycle after the corresponding mem_req.
- instr_valid  out  1  FIFO non-empty.
- instr  out  DW  head instruction; 0 when empty.
- instr_pc  out  AW  PC of head instruction; 0 when empty.
- instr_take  in  1  consumer pops head this cycle; ignored when instr_valid=0.

Behaviour:
- Reset (reset=1 at posedge):
  - fetch_pc=0, count=0, rd/wr pointers=0, inflight=0.
  - mem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - Applying reset mid-operation drops everything, including any in-flight response.
- Issue rule: mem_req = !halt && !flush && (count + inflight < DEPTH).
  - mem_addr = fetch_pc at all times.
  - On an issue, inflight<=1, the issued PC is stored in a tag register, and fetch_pc<=fetch_pc+1 (modulo 2^AW; 8'hFF wraps to 8'h00).
  - With no issue, inflight<=0.
  - Credit check counts inflight, so the FIFO never overflows; a same-cycle take is not credited for issue.
- Response: if inflight=1 and flush=0, {mem_q, tag} is written at wr_ptr, wr_ptr increments, and count increments.
- Pop: if instr_take=1, count>0 and flush=0, rd_ptr increments and count decrements.
  - Simultaneous write and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Flush (highest priority after reset):
  - count<=0, pointers<=0, inflight<=0, fetch_pc<=flush_pc.
  - The response arriving in the flush cycle is discarded, and mem_req=0 in the flush cycle.
  - The next cycle issues flush_pc, provided halt=0.
  - A flush together with instr_take discards the take.
- Halt: stops issuing only. Queued entries remain poppable. Releasing halt resumes at the unchanged fetch_pc.
- Latency:
  - Request in cycle t, entry visible (instr_valid=1) in cycle t+2.
  - After reset deassert, the first issue is in cycle 0 and instr_valid rises in cycle 2.
  - Steady-state throughput is limited to 1 issue per cycle and is throttled by credit.
- Outputs instr/instr_pc/instr_valid are combinational from the FIFO head and count. No bypass from mem_q.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined:
  - Adds output discard_count, width 16.
  - On each flush, discard_count increments by (count + inflight), saturating at 16'hFFFF.
  - discard_count resets to 0 on reset.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then hold halt=0, take=0, and memory returns addr^8'hA5. mem_req is high in cycles 0..3 with addr 0..3 and drops in cycle 4 (full). instr_valid rises in cycle 2. The head is instr=8'hA5, instr_pc=0.
- Full queue, then take=1 every cycle. Entries pop in PC order 0,1,2,3,4,... with no gaps after refill latency, and count never exceeds 4.
- Flush with flush_pc=8'h40 while count=3 and inflight=1. The next cycle gives instr_valid=0 and mem_req=0 in the flush cycle. The following cycle has mem_req=1 with addr 8'h40, and the first popped instr_pc=8'h40. With PREFETCH_STATS_EN, discard_count=4.
- Flush with flush_pc=8'hFE, take every cycle. Popped PCs are 8'hFE, 8'hFF, 8'h00, 8'h01 (wrap-around).
- halt=1 with one request in flight. The response is still enqueued and no new mem_req is issued. Releasing halt issues the next sequential PC.
- Assert reset while count=2 with a response in flight. After reset deasserts, instr_valid stays 0 for 2 cycles, and the first entry has pc 0.
